mux_scan_sampler: RTL and testbench

- Sequential scanner sitting directly upstream and downstream of the 16:1 single-bit plexer in the single-cycle CPU datapath.
- Drives the plexer's 4-bit select and enable, and samples the plexer's single-bit output on every select value.
- Assembles the 16 samples into a registered 16-bit snapshot with a done pulse and a change flag.
- Used to serialise-capture 16 status or debug bits through one plexer instance, once or continuously.

---
 rtl/mux_scan_sampler_if.sv | 24 ++
 rtl/mux_scan_sampler.sv | 98 +++++++++
 tb/tb_mux_scan_sampler.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_sampler_if.sv
// Handshake bundle between the scan sequencer and its user / the 16:1 plexer.
// The slave modport is the sampler; the master modport is whatever drives it.
interface mux_scan_sampler_if;
    logic        start;
    logic        continuous;
    logic        abort;
    logic        sample_in;
    logic [3:0]  sel;
    logic        mux_enable;
    logic        busy;
    logic        done;
    logic        changed;
    logic [15:0] snapshot;

    modport slave (
        input  start, continuous, abort, sample_in,
        output sel, mux_enable, busy, done, changed, snapshot
    );

    modport master (
        output start, continuous, abort, sample_in,
        input  sel, mux_enable, busy, done, changed, snapshot
    );
endinterface

// File: rtl/mux_scan_sampler.sv
// Walks a 16:1 plexer select through 0..15 and captures its output into a 16-bit snapshot.
//   state  | meaning
//   S_IDLE | plexer disabled, waiting for start
//   S_SCAN | stepping select, sampling after SETTLE_CYCLES extra cycles per bit
module mux_scan_sampler #(
    parameter int SETTLE_CYCLES = 0
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    mux_scan_sampler_if.slave  bus
);
    localparam logic [3:0] C_SETTLE = 4'(SETTLE_CYCLES);

    typedef enum logic {S_IDLE, S_SCAN} state_t;

    state_t      r_state;
    logic [3:0]  r_sel;
    logic [3:0]  r_cnt;
    logic        r_en;
    logic        r_busy;
    logic        r_done;
    logic        r_changed;
    logic [15:0] r_shadow;
    logic [15:0] r_snapshot;
    logic [15:0] w_new_snap;

    // Bit 15 is taken straight from the plexer on the completing edge.
    always_comb begin
        w_new_snap     = r_shadow;
        w_new_snap[15] = bus.sample_in;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_sel      <= 4'd0;
            r_cnt      <= 4'd0;
            r_en       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_changed  <= 1'b0;
            r_shadow   <= 16'h0000;
            r_snapshot <= 16'h0000;
        end else begin
            r_done    <= 1'b0;
            r_changed <= 1'b0;
            if (bus.abort) begin
                r_state  <= S_IDLE;
                r_sel    <= 4'd0;
                r_cnt    <= 4'd0;
                r_en     <= 1'b0;
                r_busy   <= 1'b0;
                r_shadow <= 16'h0000;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start) begin
                            r_state <= S_SCAN;
                            r_sel   <= 4'd0;
                            r_cnt   <= 4'd0;
                            r_en    <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_SCAN: begin
                        if (r_cnt != C_SETTLE) begin
                            r_cnt <= r_cnt + 4'd1;
                        end else begin
                            r_cnt           <= 4'd0;
                            r_shadow[r_sel] <= bus.sample_in;
                            if (r_sel != 4'd15) begin
                                r_sel <= r_sel + 4'd1;
                            end else begin
                                r_snapshot <= w_new_snap;
                                r_changed  <= (w_new_snap != r_snapshot);
                                r_done     <= 1'b1;
                                r_sel      <= 4'd0;
                                if (!bus.continuous) begin
                                    r_state <= S_IDLE;
                                    r_en    <= 1'b0;
                                    r_busy  <= 1'b0;
                                end
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.sel        = r_sel;
    assign bus.mux_enable = r_en;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.changed    = r_changed;
    assign bus.snapshot   = r_snapshot;
endmodule

// File: tb/tb_mux_scan_sampler.sv
// Directed bench for mux_scan_sampler: one instance with no settle delay, one with three.
module tb_mux_scan_sampler;
    logic        clk;
    logic        rst_n;
    logic [15:0] pat0;
    logic [15:0] pat1;
    int          n_checks;
    int          n_errors;

    mux_scan_sampler_if if0 ();
    mux_scan_sampler_if if1 ();

    assign if0.sample_in = pat0[if0.sel];
    assign if1.sample_in = pat1[if1.sel];

    mux_scan_sampler #(.SETTLE_CYCLES(0)) u_dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(if0.slave));
    mux_scan_sampler #(.SETTLE_CYCLES(3)) u_dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(if1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_checks++; if (if0.sel !== 4'd0)        begin n_errors++; $display("FAIL reset_sel got %h exp 0", if0.sel); end
        n_checks++; if (if0.mux_enable !== 1'b0) begin n_errors++; $display("FAIL reset_en got %b exp 0", if0.mux_enable); end
        n_checks++; if (if0.busy !== 1'b0)       begin n_errors++; $display("FAIL reset_busy got %b exp 0", if0.busy); end
        n_checks++; if (if0.done !== 1'b0)       begin n_errors++; $display("FAIL reset_done got %b exp 0", if0.done); end
        n_checks++; if (if0.changed !== 1'b0)    begin n_errors++; $display("FAIL reset_changed got %b exp 0", if0.changed); end
        n_checks++; if (if0.snapshot !== 16'h0)  begin n_errors++; $display("FAIL reset_snap got %h exp 0000", if0.snapshot); end
        n_checks++; if (if1.busy !== 1'b0)       begin n_errors++; $display("FAIL reset_busy1 got %b exp 0", if1.busy); end
    endtask

    task automatic test_basic();
        pat0 = 16'hA5C3;
        if0.start = 1'b1;
        step();
        if0.start = 1'b0;
        n_checks++; if (if0.busy !== 1'b1 || if0.mux_enable !== 1'b1 || if0.sel !== 4'd0) begin
            n_errors++; $display("FAIL basic_start got busy=%b en=%b sel=%h exp 1 1 0", if0.busy, if0.mux_enable, if0.sel);
        end
        for (int e = 1; e <= 15; e++) begin
            step();
            n_checks++; if (if0.sel !== 4'(e) || if0.done !== 1'b0) begin
                n_errors++; $display("FAIL basic_sel edge %0d got sel=%h done=%b exp sel=%h done=0", e, if0.sel, if0.done, 4'(e));
            end
        end
        step();
        n_checks++; if (if0.done !== 1'b1)          begin n_errors++; $display("FAIL basic_done got %b exp 1", if0.done); end
        n_checks++; if (if0.snapshot !== 16'hA5C3)  begin n_errors++; $display("FAIL basic_snap got %h exp a5c3", if0.snapshot); end
        n_checks++; if (if0.changed !== 1'b1)       begin n_errors++; $display("FAIL basic_changed got %b exp 1", if0.changed); end
        n_checks++; if (if0.busy !== 1'b0 || if0.mux_enable !== 1'b0 || if0.sel !== 4'd0) begin
            n_errors++; $display("FAIL basic_end got busy=%b en=%b sel=%h exp 0 0 0", if0.busy, if0.mux_enable, if0.sel);
        end
        step();
        n_checks++; if (if0.done !== 1'b0 || if0.changed !== 1'b0) begin
            n_errors++; $display("FAIL basic_pulse got done=%b changed=%b exp 0 0", if0.done, if0.changed);
        end
    endtask

    task automatic test_settle();
        pat1 = 16'h0001;
        if1.start = 1'b1;
        step();
        if1.start = 1'b0;
        for (int e = 1; e <= 63; e++) begin
            step();
            n_checks++; if (if1.sel !== 4'(e / 4) || if1.done !== 1'b0) begin
                n_errors++; $display("FAIL settle_sel edge %0d got sel=%h done=%b exp sel=%h done=0", e, if1.sel, if1.done, 4'(e / 4));
            end
        end
        step();
        n_checks++; if (if1.done !== 1'b1 || if1.snapshot !== 16'h0001 || if1.changed !== 1'b1) begin
            n_errors++; $display("FAIL settle_done got done=%b snap=%h chg=%b exp 1 0001 1", if1.done, if1.snapshot, if1.changed);
        end
        n_checks++; if (if1.busy !== 1'b0) begin n_errors++; $display("FAIL settle_busy got %b exp 0", if1.busy); end
    endtask

    task automatic test_continuous();
        logic [15:0] exp_snap;
        logic        exp_chg;
        pat0 = 16'hFFFF;
        if0.continuous = 1'b1;
        if0.start = 1'b1;
        step();
        if0.start = 1'b0;
        for (int e = 1; e <= 80; e++) begin
            step();
            if (e == 40) pat0 = 16'hFFFE;
            if (e == 72) if0.continuous = 1'b0;
            n_checks++; if (if0.done !== ((e % 16) == 0)) begin
                n_errors++; $display("FAIL cont_done edge %0d got %b exp %b", e, if0.done, ((e % 16) == 0));
            end
            n_checks++; if (if0.busy !== (e < 80)) begin
                n_errors++; $display("FAIL cont_busy edge %0d got %b exp %b", e, if0.busy, (e < 80));
            end
            if ((e % 16) == 0) begin
                exp_snap = (e < 64) ? 16'hFFFF : 16'hFFFE;
                exp_chg  = (e == 16) || (e == 64);
                n_checks++; if (if0.snapshot !== exp_snap || if0.changed !== exp_chg) begin
                    n_errors++; $display("FAIL cont_snap edge %0d got %h/%b exp %h/%b", e, if0.snapshot, if0.changed, exp_snap, exp_chg);
                end
            end
        end
    endtask

    task automatic test_abort();
        pat0 = 16'h1234;
        if0.start = 1'b1;
        step();
        if0.start = 1'b0;
        for (int e = 1; e <= 16; e++) step();
        n_checks++; if (if0.snapshot !== 16'h1234 || if0.changed !== 1'b1) begin
            n_errors++; $display("FAIL abort_prep got %h/%b exp 1234/1", if0.snapshot, if0.changed);
        end
        pat0 = 16'h5678;
        if0.start = 1'b1;
        step();
        if0.start = 1'b0;
        for (int e = 1; e <= 7; e++) step();
        n_checks++; if (if0.sel !== 4'd7) begin n_errors++; $display("FAIL abort_presel got %h exp 7", if0.sel); end
        if0.abort = 1'b1;
        step();
        if0.abort = 1'b0;
        n_checks++; if (if0.busy !== 1'b0 || if0.sel !== 4'd0 || if0.mux_enable !== 1'b0 || if0.done !== 1'b0) begin
            n_errors++; $display("FAIL abort_mid got busy=%b sel=%h en=%b done=%b exp 0 0 0 0", if0.busy, if0.sel, if0.mux_enable, if0.done);
        end
        n_checks++; if (if0.snapshot !== 16'h1234) begin n_errors++; $display("FAIL abort_snap got %h exp 1234", if0.snapshot); end
        for (int e = 0; e < 12; e++) begin
            step();
            n_checks++; if (if0.done !== 1'b0 || if0.busy !== 1'b0) begin
                n_errors++; $display("FAIL abort_quiet got done=%b busy=%b exp 0 0", if0.done, if0.busy);
            end
        end
        if0.start = 1'b1;
        if0.abort = 1'b1;
        step();
        if0.start = 1'b0;
        if0.abort = 1'b0;
        n_checks++; if (if0.busy !== 1'b0 || if0.mux_enable !== 1'b0) begin
            n_errors++; $display("FAIL abort_start got busy=%b en=%b exp 0 0", if0.busy, if0.mux_enable);
        end
        step();
        n_checks++; if (if0.busy !== 1'b0) begin n_errors++; $display("FAIL abort_idle got %b exp 0", if0.busy); end
        // Abort landing exactly on the bit-15 sample edge
        if0.start = 1'b1;
        step();
        if0.start = 1'b0;
        for (int e = 1; e <= 15; e++) step();
        if0.abort = 1'b1;
        step();
        if0.abort = 1'b0;
        n_checks++; if (if0.done !== 1'b0 || if0.snapshot !== 16'h1234 || if0.busy !== 1'b0) begin
            n_errors++; $display("FAIL abort_last got done=%b snap=%h busy=%b exp 0 1234 0", if0.done, if0.snapshot, if0.busy);
        end
    endtask

    task automatic test_async_reset();
        pat0 = 16'h5678;
        if0.start = 1'b1;
        step();
        if0.start = 1'b0;
        for (int e = 1; e <= 9; e++) step();
        n_checks++; if (if0.sel !== 4'd9) begin n_errors++; $display("FAIL areset_presel got %h exp 9", if0.sel); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (if0.busy !== 1'b0 || if0.sel !== 4'd0 || if0.mux_enable !== 1'b0) begin
            n_errors++; $display("FAIL areset_out got busy=%b sel=%h en=%b exp 0 0 0", if0.busy, if0.sel, if0.mux_enable);
        end
        n_checks++; if (if0.snapshot !== 16'h0000 || if0.done !== 1'b0 || if0.changed !== 1'b0) begin
            n_errors++; $display("FAIL areset_snap got snap=%h done=%b chg=%b exp 0000 0 0", if0.snapshot, if0.done, if0.changed);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        if0.start = 1'b1;
        step();
        if0.start = 1'b0;
        for (int e = 1; e <= 16; e++) step();
        n_checks++; if (if0.done !== 1'b1 || if0.snapshot !== 16'h5678 || if0.changed !== 1'b1) begin
            n_errors++; $display("FAIL areset_rescan got done=%b snap=%h chg=%b exp 1 5678 1", if0.done, if0.snapshot, if0.changed);
        end
    endtask

    task automatic test_start_while_busy();
        int n_done;
        n_done = 0;
        pat0 = 16'h9ABC;
        if0.start = 1'b1;
        step();
        if0.start = 1'b0;
        for (int e = 1; e <= 24; e++) begin
            if (e == 6) if0.start = 1'b1;
            step();
            if (e == 6) if0.start = 1'b0;
            if (if0.done === 1'b1) n_done++;
            if (e == 16) begin
                n_checks++; if (if0.done !== 1'b1 || if0.snapshot !== 16'h9ABC) begin
                    n_errors++; $display("FAIL busy_start_done got done=%b snap=%h exp 1 9abc", if0.done, if0.snapshot);
                end
            end
        end
        n_checks++; if (n_done != 1) begin n_errors++; $display("FAIL busy_start_count got %0d exp 1", n_done); end
    endtask

    task automatic test_back_to_back();
        pat0 = 16'h0F0F;
        if0.start = 1'b1;
        step();
        for (int e = 1; e <= 16; e++) step();
        n_checks++; if (if0.done !== 1'b1 || if0.busy !== 1'b0 || if0.snapshot !== 16'h0F0F) begin
            n_errors++; $display("FAIL b2b_first got done=%b busy=%b snap=%h exp 1 0 0f0f", if0.done, if0.busy, if0.snapshot);
        end
        step();
        n_checks++; if (if0.busy !== 1'b1 || if0.sel !== 4'd0 || if0.done !== 1'b0) begin
            n_errors++; $display("FAIL b2b_restart got busy=%b sel=%h done=%b exp 1 0 0", if0.busy, if0.sel, if0.done);
        end
        if0.start = 1'b0;
        pat0 = 16'hF0F0;
        for (int e = 1; e <= 16; e++) step();
        n_checks++; if (if0.done !== 1'b1 || if0.snapshot !== 16'hF0F0 || if0.changed !== 1'b1) begin
            n_errors++; $display("FAIL b2b_second got done=%b snap=%h chg=%b exp 1 f0f0 1", if0.done, if0.snapshot, if0.changed);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        pat0 = 16'h0;
        pat1 = 16'h0;
        if0.start = 1'b0; if0.continuous = 1'b0; if0.abort = 1'b0;
        if1.start = 1'b0; if1.continuous = 1'b0; if1.abort = 1'b0;
        rst_n = 1'b0;
        #23;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        test_basic();
        test_settle();
        test_continuous();
        test_abort();
        test_async_reset();
        test_start_while_busy();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end
endmodule
